prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Program controller for the 4-bit proc core. Holds a 16-entry program store, loaded over a write port.
- Drives the core's 12-bit instruction input one word per instruction slot, timed to the core's 5-phase cycle (fetch, op1, op2, decode, execute).
- Advances the PC, applies jump redirects returned by the core, and supports run, single-step and halt.

Parameters:
- DEPTH, 16, program store entries; power of two; PC width is clog2(DEPTH).
- IW, 12, instruction width: [11:8] opcode, [7:4] op2, [3:0] op1.
- SLOT_CYCLES, 5, cycles each instruction word is held on the instruction output; must be at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- ld_valid  in  1  program-store write request.
- ld_addr  in  clog2(DEPTH)  write address.
- ld_data  in  IW  write data.
- ld_ready  out  1  write accepted this cycle when ld_valid is also high.
- start  in  1  pulse: begin free-running execution at PC 0.
- step  in  1  pulse: execute exactly one instruction.
- halt_req  in  1  pulse: stop at the next slot boundary.
- jmp_valid  in  1  core reports a taken branch; sampled only in the last cycle of a slot.
- jmp_target  in  clog2(DEPTH)  branch destination.
- instruction  out  IW  word presented to the core.
- pc  out  clog2(DEPTH)  address of the current or next word.
- core_rst  out  1  held-reset output to the core.
- busy  out  1  high in RUN or STEP.
- done  out  1  high in HALTED.

Behaviour:
- Reset values:
  - State IDLE.
  - instruction=0, pc=0, busy=0, done=0, ld_ready=1, core_rst=1.
  - Phase counter 0.
  - Store contents are not reset.
- States: IDLE, RUN, STEP, PAUSE, HALTED.
- IDLE:
  - ld_ready=1; a write lands when ld_valid=1.
  - core_rst=1 and instruction=0.
  - start moves to RUN; step moves to STEP. In both cases pc=0 and phase=0.
  - If ld_valid and start arrive in the same cycle, the write completes and RUN begins on the next cycle.
- RUN and STEP:
  - ld_ready=0 and core_rst=0.
  - instruction = store[pc], registered, so it is valid in the first cycle of the slot.
  - The phase counter counts 0..SLOT_CYCLES-1 and wraps.
- Slot end (phase == SLOT_CYCLES-1):
  - pc_next = jmp_valid ? jmp_target : pc+1.
  - jmp_valid outside this cycle is ignored.
- Halt word: if the word fetched at slot start is all-zero, the state moves to HALTED at the end of that slot and pc does not advance.
- PC wrap: if pc == DEPTH-1 at slot end without a jump, the state goes to HALTED and pc stays at DEPTH-1.
- halt_req in RUN: latched; the state goes to PAUSE at the end of the current slot. The slot always completes, so the core is never starved mid-instruction.
- STEP: at the end of the slot, the state goes to PAUSE with pc updated.
- PAUSE:
  - instruction=0 and busy=0; core_rst is not asserted.
  - start resumes RUN at the current pc; step runs one slot.
  - If start and step arrive in the same cycle, start wins.
- HALTED:
  - done=1 and instruction=0.
  - start restarts at pc 0 and clears done. step is ignored.
  - A rst pulse returns to IDLE.
- If ld_valid arrives outside IDLE, ld_ready=0 and the write is dropped.
- rst mid-slot aborts immediately; the next cycle shows IDLE reset values.

Optional Feature:
- Macro SEQ_BREAKPOINT_EN.
- When defined, the block adds two inputs:
  - bp_valid, 1 bit.
  - bp_addr, clog2(DEPTH) bits.
- While bp_valid=1, a slot about to start in RUN with pc==bp_addr does not start. The state goes to PAUSE with that pc and a sticky bp_hit output goes high. bp_hit clears on start or step.
- Resuming from a breakpoint executes that instruction first; the breakpoint does not re-trigger until pc leaves bp_addr.
- When not defined: no ports and no logic; behaviour is exactly as above.

Decomposition:
- Shared package proc_pkg holds:
  - instructions_t, moved out of the core.
  - seq_state_t (IDLE, RUN, STEP, PAUSE, HALTED).
  - The HALT_WORD constant ('0).
- One sub-module, seq_imem: DEPTH x IW store with synchronous write and registered read.
- The FSM, phase counter and PC logic stay in prog_sequencer.

Test Plan:
- Load 3'h0=0x1_2_3 (ADD), 3'h1=0x000; start -> instruction=0x123 for 5 cycles from the slot start, then 0x000 for one slot; done=1, pc=1.
- Load addr0=JMP word, addr1 nonzero; start; assert jmp_valid with target 4 in cycle 4 of slot 0 -> next slot pc=4; a jmp_valid pulse in cycle 2 has no effect.
- Run a 4-word program; halt_req in cycle 1 of slot 1 -> slot 1 completes, PAUSE with pc=2; step -> exactly one slot at pc 2, then PAUSE with pc=3.
- Fill all 16 entries nonzero; start -> 16 slots (80 cycles) then HALTED with pc=15 and no wrap to 0.
- rst in cycle 3 of a slot -> next cycle instruction=0, core_rst=1, busy=0, state IDLE; the previously loaded store content is still readable on restart.
- ld_valid during RUN -> ld_ready=0 and the entry is unchanged; under SEQ_BREAKPOINT_EN with bp_addr=2 -> PAUSE at pc=2 and bp_hit=1, and start executes word 2.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, sequencer-state and halt-word definitions for the proc core
package proc_pkg;

  typedef enum logic [3:0] {
    OP_HALT = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LD   = 4'h6,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9
  } instructions_t;

  typedef enum logic [2:0] {IDLE, RUN, STEP, PAUSE, HALTED} seq_state_t;

  localparam int PROC_IW = 12;
  localparam logic [PROC_IW-1:0] HALT_WORD = '0;

endpackage

// File: rtl/seq_imem.sv
// rtl/seq_imem.sv - DEPTH x IW program store, synchronous write, registered read
// A write to the address being read is forwarded so a same-cycle load+start sees the new word.
module seq_imem #(
  parameter int DEPTH = 16,
  parameter int IW    = 12,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= (we && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program controller feeding the proc core one word per SLOT_CYCLES slot
// Optional breakpoint support is enabled by defining SEQ_BREAKPOINT_EN.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int IW          = 12,
  parameter int SLOT_CYCLES = 5,
  localparam int AW         = $clog2(DEPTH),
  localparam int PW         = $clog2(SLOT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          start,
  input  logic          step,
  input  logic          halt_req,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_target,
`ifdef SEQ_BREAKPOINT_EN
  input  logic          bp_valid,
  input  logic [AW-1:0] bp_addr,
  output logic          bp_hit,
`endif
  output logic [IW-1:0] instruction,
  output logic [AW-1:0] pc,
  output logic          core_rst,
  output logic          busy,
  output logic          done
);

  seq_state_t    state;
  logic [PW-1:0] phase;
  logic          halt_pend;
  logic [AW-1:0] pc_nxt;
  logic [IW-1:0] rd_data;
  logic          slot_end, halt_word, wrap_stop, bp_stop;

  assign slot_end    = (phase == PW'(SLOT_CYCLES - 1));
  assign halt_word   = (rd_data == IW'(HALT_WORD));
  assign wrap_stop   = (pc == AW'(DEPTH - 1)) && !jmp_valid;
  assign instruction = busy ? rd_data : '0;

  // The store is read at the next-cycle pc so the word is ready in the first cycle of a slot.
  seq_imem #(.DEPTH(DEPTH), .IW(IW)) u_imem (
    .clk     (clk),
    .we      (ld_valid && ld_ready),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (pc_nxt),
    .rd_data (rd_data)
  );

  always_comb begin
    pc_nxt = pc;
    if (rst) begin
      pc_nxt = '0;
    end else begin
      case (state)
        IDLE: pc_nxt = '0;
        RUN, STEP: begin
          if (slot_end && !halt_word) begin
            if (jmp_valid) pc_nxt = jmp_target;
            else if (!wrap_stop) pc_nxt = pc + 1'b1;
          end
        end
        HALTED: if (start) pc_nxt = '0;
        default: pc_nxt = pc;
      endcase
    end
  end

`ifdef SEQ_BREAKPOINT_EN
  logic bp_skip;

  // bp_skip lets a resumed breakpoint word execute once before the address can trip again.
  assign bp_stop = (state == RUN) && slot_end && !halt_word && !wrap_stop &&
                   bp_valid && !bp_skip && (pc_nxt == bp_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit  <= 1'b0;
      bp_skip <= 1'b0;
    end else if (bp_stop) begin
      bp_hit  <= 1'b1;
      bp_skip <= 1'b1;
    end else begin
      if (start || step) bp_hit <= 1'b0;
      if (pc != bp_addr) bp_skip <= 1'b0;
    end
  end
`else
  assign bp_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    pc <= pc_nxt;
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      halt_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ld_ready  <= 1'b1;
      core_rst  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start || step) begin
            state    <= start ? RUN : STEP;
            phase    <= '0;
            busy     <= 1'b1;
            ld_ready <= 1'b0;
            core_rst <= 1'b0;
          end
        end
        RUN, STEP: begin
          phase <= slot_end ? '0 : phase + 1'b1;
          if (!slot_end) begin
            halt_pend <= halt_pend | (halt_req && state == RUN);
          end else begin
            halt_pend <= 1'b0;
            if (halt_word || wrap_stop) begin
              state <= HALTED;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (state == STEP || halt_pend || halt_req || bp_stop) begin
              state <= PAUSE;
              busy  <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (start || step) begin
            state <= start ? RUN : STEP;
            phase <= '0;
            busy  <= 1'b1;
          end
        end
        HALTED: begin
          if (start) begin
            state <= RUN;
            phase <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - scoreboard bench for prog_sequencer (breakpoint case under SEQ_BREAKPOINT_EN)
module tb_prog_sequencer;
  import proc_pkg::*;

  localparam int AW = 4;
  localparam int IW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [IW-1:0] ld_data = '0;
  logic          start = 1'b0, step = 1'b0, halt_req = 1'b0, jmp_valid = 1'b0;
  logic [AW-1:0] jmp_target = '0;
  logic          ld_ready, core_rst, busy, done;
  logic [IW-1:0] instruction;
  logic [AW-1:0] pc;
`ifdef SEQ_BREAKPOINT_EN
  logic          bp_valid = 1'b0;
  logic [AW-1:0] bp_addr = '0;
  logic          bp_hit;
`endif

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  prog_sequencer #(.DEPTH(16), .IW(IW), .SLOT_CYCLES(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .start       (start),
    .step        (step),
    .halt_req    (halt_req),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
`ifdef SEQ_BREAKPOINT_EN
    .bp_valid    (bp_valid),
    .bp_addr     (bp_addr),
    .bp_hit      (bp_hit),
`endif
    .instruction (instruction),
    .pc          (pc),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic push_slot(input logic [AW-1:0] p, input logic [IW-1:0] w);
    for (int k = 0; k < 5; k++) exp_q.push_back(exp_t'({p, w}));
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  task automatic pulse_halt();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic wait_stop(input string name, input int max_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: busy=%0b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  // Monitor: every cycle the core is fed, the presented pc/word must match the next queued slot.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_busy: pc=%0d instr=0x%0h, expected no active slot", pc, instruction);
      end else begin
        mon_e = exp_q.pop_front();
        check("slot_pc", 32'(pc), 32'(mon_e.pc));
        check("slot_instr", 32'(instruction), 32'(mon_e.instr));
      end
    end
  end

  initial begin
    // Reset values
    do_reset();
    check("rst_instruction", 32'(instruction), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ld_ready", 32'(ld_ready), 32'h1);
    check("rst_core_rst", 32'(core_rst), 32'h1);

    // ADD then halt word; word 0 written in the same cycle as start
    load(4'h1, 12'h000);
    push_slot(4'h0, 12'h123);
    push_slot(4'h1, 12'h000);
    ld_valid = 1'b1; ld_addr = 4'h0; ld_data = 12'h123; start = 1'b1;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    wait_stop("t1_wait", 30);
    check("t1_done", 32'(done), 32'h1);
    check("t1_pc", 32'(pc), 32'h1);
    check("t1_instr_halted", 32'(instruction), 32'h0);
    check("t1_ld_ready_halted", 32'(ld_ready), 32'h0);

    // Jump: stray pulse in cycle 2 ignored, pulse in cycle 4 redirects to 4
    do_reset();
    load(4'h0, {OP_JMP, 4'h0, 4'h4});
    load(4'h1, 12'h111);
    load(4'h4, 12'h000);
    push_slot(4'h0, 12'h804);
    push_slot(4'h4, 12'h000);
    pulse_start();
    tick(); tick();
    jmp_valid = 1'b1; jmp_target = 4'h7;
    tick();
    jmp_valid = 1'b0;
    tick();
    jmp_valid = 1'b1; jmp_target = 4'h4;
    tick();
    jmp_valid = 1'b0;
    wait_stop("t2_wait", 30);
    check("t2_pc", 32'(pc), 32'h4);
    check("t2_done", 32'(done), 32'h1);

    // halt_req in cycle 1 of slot 1, then single step
    do_reset();
    load(4'h0, 12'h101);
    load(4'h1, 12'h202);
    load(4'h2, 12'h303);
    load(4'h3, 12'h404);
    push_slot(4'h0, 12'h101);
    push_slot(4'h1, 12'h202);
    pulse_start();
    for (int i = 0; i < 6; i++) tick();
    pulse_halt();
    wait_stop("t3_wait_pause", 30);
    check("t3_pause_pc", 32'(pc), 32'h2);
    check("t3_pause_done", 32'(done), 32'h0);
    check("t3_pause_instr", 32'(instruction), 32'h0);
    check("t3_pause_core_rst", 32'(core_rst), 32'h0);
    check("t3_pause_ld_ready", 32'(ld_ready), 32'h0);
    push_slot(4'h2, 12'h303);
    pulse_step();
    wait_stop("t3_wait_step", 30);
    check("t3_step_pc", 32'(pc), 32'h3);
    check("t3_step_done", 32'(done), 32'h0);

    // Full store, no wrap past the last entry
    do_reset();
    for (int i = 0; i < 16; i++) begin
      load(4'(i), 12'h100 | 12'(i << 4) | 12'(15 - i));
      push_slot(4'(i), 12'h100 | 12'(i << 4) | 12'(15 - i));
    end
    pulse_start();
    wait_stop("t4_wait", 120);
    check("t4_pc", 32'(pc), 32'hF);
    check("t4_done", 32'(done), 32'h1);

    // rst in cycle 3 of a slot, store content survives
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_t'({4'h0, 12'h10F}));
    pulse_start();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_instr", 32'(instruction), 32'h0);
    check("t5_core_rst", 32'(core_rst), 32'h1);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_ld_ready", 32'(ld_ready), 32'h1);
    check("t5_pc", 32'(pc), 32'h0);
    check("t5_done", 32'(done), 32'h0);
    push_slot(4'h0, 12'h10F);
    pulse_start();
    pulse_halt();
    wait_stop("t5_wait", 30);
    check("t5_pause_pc", 32'(pc), 32'h1);

    // Writes outside IDLE are dropped
    push_slot(4'h1, 12'h11E);
    pulse_start();
    ld_valid = 1'b1; ld_addr = 4'h2; ld_data = 12'hABC;
    check("t6_ld_ready_run", 32'(ld_ready), 32'h0);
    tick();
    ld_valid = 1'b0;
    pulse_halt();
    wait_stop("t6_wait", 30);
    check("t6_pause_pc", 32'(pc), 32'h2);
    push_slot(4'h2, 12'h12D);
    pulse_step();
    wait_stop("t6_wait_step", 30);
    check("t6_step_pc", 32'(pc), 32'h3);

`ifdef SEQ_BREAKPOINT_EN
    // Breakpoint at 2, resume executes word 2 first
    do_reset();
    bp_valid = 1'b1; bp_addr = 4'h2;
    push_slot(4'h0, 12'h10F);
    push_slot(4'h1, 12'h11E);
    pulse_start();
    wait_stop("t7_wait_bp", 30);
    check("t7_bp_pc", 32'(pc), 32'h2);
    check("t7_bp_hit", 32'(bp_hit), 32'h1);
    check("t7_bp_done", 32'(done), 32'h0);
    push_slot(4'h2, 12'h12D);
    pulse_start();
    check("t7_bp_hit_cleared", 32'(bp_hit), 32'h0);
    pulse_halt();
    wait_stop("t7_wait_resume", 30);
    check("t7_resume_pc", 32'(pc), 32'h3);
    bp_valid = 1'b0;
`endif

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
